// File: rtl/uart_rx_byte_if.sv
// Byte-receiver bundle: raw serial line in, byte/strobe/status out.
// master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_byte_if;
  logic       i_rx;
  logic [7:0] o_rx_dat;
  logic       o_rx_done;
  logic       o_frame_err;
  logic       o_busy;

  modport master (input i_rx, output o_rx_dat, output o_rx_done, output o_frame_err, output o_busy);
  modport slave  (output i_rx, input o_rx_dat, input o_rx_done, input o_frame_err, input o_busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first, mid-bit sampling on the synchronised line.
// Define UART_RX_PARITY_EN for 8E1/8O1 (parity_odd selects odd parity).
module uart_rx_byte #(
  parameter int clks_per_bit = 139,
  parameter int cw           = $clog2(clks_per_bit)
`ifdef UART_RX_PARITY_EN
  , parameter bit parity_odd = 1'b0
`endif
) (
  input logic            i_wb_clk,
  input logic            i_wb_rst,
  uart_rx_byte_if.master bus
);

  localparam logic [cw-1:0] LAST    = cw'(clks_per_bit - 1);
  localparam logic [cw-1:0] HALF_M1 = cw'((clks_per_bit - 1) / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } st_t;

  st_t           st_q;
  logic          rx_m_q, rx_s_q;
  logic [cw-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q, dat_q;
  logic          done_q, ferr_q, busy_q;
  logic          par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign par_ok = !par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      st_q      <= S_IDLE;
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      rx_m_q <= bus.i_rx;
      rx_s_q <= rx_m_q;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (st_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) begin
            st_q   <= S_START;
            busy_q <= 1'b1;
          end
        end
        // Half a bit in: a line that is high again was only a glitch.
        S_START: if (cnt_q == HALF_M1) begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_s_q) st_q <= S_DATA;
          else begin
            st_q   <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_DATA: if (cnt_q == LAST) begin
          cnt_q       <= '0;
          sh_q[idx_q] <= rx_s_q;
          idx_q       <= idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            st_q <= S_PARITY;
`else
            st_q <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (cnt_q == LAST) begin
          cnt_q     <= '0;
          par_err_q <= rx_s_q ^ (^sh_q) ^ parity_odd;
          st_q      <= S_STOP;
        end
`endif
        S_STOP: if (cnt_q == LAST) begin
          cnt_q <= '0;
          if (rx_s_q) begin
            st_q   <= S_IDLE;
            busy_q <= 1'b0;
            if (par_ok) begin
              dat_q  <= sh_q;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            ferr_q <= 1'b1;
            st_q   <= S_WAIT_IDLE;
          end
        end
        // Hold off through a break so it never decodes as a 0x00 frame.
        S_WAIT_IDLE: begin
          cnt_q <= '0;
          if (rx_s_q) begin
            st_q   <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_rx_dat    = dat_q;
  assign bus.o_rx_done   = done_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = busy_q;

endmodule
